// File: rtl/csa_bist_ctrl.sv
// csa_bist_ctrl: stimulus/response self-test controller for the carry-skip adder.
// Latency: SETTLE+2 cycles per vector; start-to-done N*(SETTLE+2)+1 cycles.
// Backpressure: none; start is ignored unless idle or done.
//
// Ports:
//   clk, rst_n (sync, active-low), start    : clock, reset, run request pulse
//   a_o, b_o, cin_o                         : registered operands to the adder
//   sum_i, cout_i                           : adder response
//   busy, done, pass                        : run status; pass is valid while done=1
//   err_count, first_fail_idx               : mismatch count (saturating), first failing index
// Build option: define CSA_BIST_EXHAUSTIVE_EN to replace the directed + LFSR
// vector set with a full sweep of {cin,b,a}.
module csa_bist_ctrl #(
    parameter int WIDTH    = 2,
    parameter int SETTLE   = 1,
    parameter int NUM_RAND = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             cin_o,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [7:0]       first_fail_idx
);

`ifdef CSA_BIST_EXHAUSTIVE_EN
    localparam int NUM_VEC = 1 << (2 * WIDTH + 1);
`else
    localparam int NUM_VEC = 8 + NUM_RAND;
`endif
    localparam logic [15:0] LAST_IDX  = 16'(NUM_VEC - 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [15:0]      vec_idx_q, vec_idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [7:0]       err_q, err_d, ffi_q, ffi_d;

    logic             accept;
    logic             is_last;
    logic             mismatch;
    logic [WIDTH:0]   expect_sum;
    logic [7:0]       idx_rep;
    logic [7:0]       err_inc;
    logic [WIDTH-1:0] vec_a, vec_b;
    logic             vec_c;

    assign accept     = start && (state_q == S_IDLE || state_q == S_DONE);
    assign is_last    = (vec_idx_q == LAST_IDX);
    assign expect_sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    assign mismatch   = ({cout_i, sum_i} != expect_sum);
    // 8'hFF means "no failure", so any index that would collide with it reads as FE.
    assign idx_rep    = (vec_idx_q > 16'd254) ? 8'hFE : vec_idx_q[7:0];
    assign err_inc    = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

`ifdef CSA_BIST_EXHAUSTIVE_EN
    // Vector index is the operand tuple itself.
    always_comb begin
        vec_a = vec_idx_q[WIDTH-1:0];
        vec_b = vec_idx_q[2*WIDTH-1:WIDTH];
        vec_c = vec_idx_q[2*WIDTH];
    end
`else
    localparam logic [WIDTH-1:0] ALL1 = '1;
    localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALT  = WIDTH'(16'hAAAA);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        vec_a = '0;
        vec_b = '0;
        vec_c = 1'b0;
        if (vec_idx_q < 16'd8) begin
            case (vec_idx_q[2:0])
                3'd0: begin vec_a = '0;   vec_b = '0;   vec_c = 1'b0; end
                3'd1: begin vec_a = ALL1; vec_b = ALL1; vec_c = 1'b1; end
                3'd2: begin vec_a = '0;   vec_b = MSB;  vec_c = 1'b0; end
                3'd3: begin vec_a = '0;   vec_b = MSB;  vec_c = 1'b1; end
                3'd4: begin vec_a = '0;   vec_b = '0;   vec_c = 1'b1; end
                3'd5: begin vec_a = ALL1; vec_b = '0;   vec_c = 1'b1; end
                3'd6: begin vec_a = ALT;  vec_b = ~ALT; vec_c = 1'b0; end
                default: begin vec_a = ~ALT; vec_b = ALT; vec_c = 1'b0; end
            endcase
        end else begin
            vec_a = lfsr_q[WIDTH-1:0];
            vec_b = lfsr_q[2*WIDTH-1:WIDTH];
            vec_c = lfsr_q[2*WIDTH];
        end
    end

    // Right-shifting Fibonacci form of taps 16,14,13,11; steps after each random vector is checked.
    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = LFSR_SEED;
        end else if (state_q == S_CHECK && vec_idx_q >= 16'd8) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_APPLY;
            S_APPLY:        state_d = S_WAIT;
            S_WAIT:         if (cnt_q <= 4'd1) state_d = S_CHECK;
            S_CHECK:        state_d = is_last ? S_DONE : S_APPLY;
            default:        state_d = S_IDLE;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        vec_idx_d = vec_idx_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_d     = err_q;
        ffi_d     = ffi_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_idx_d = '0;
                    err_d     = '0;
                    ffi_d     = 8'hFF;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_APPLY: begin
                a_d   = vec_a;
                b_d   = vec_b;
                cin_d = vec_c;
                cnt_d = 4'(SETTLE);
            end
            S_WAIT: cnt_d = cnt_q - 4'd1;
            S_CHECK: begin
                if (mismatch) begin
                    err_d = err_inc;
                    if (ffi_q == 8'hFF) ffi_d = idx_rep;
                end
                if (is_last) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_d == 8'd0);
                end else begin
                    vec_idx_d = vec_idx_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_idx_q <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ffi_q     <= 8'hFF;
        end else begin
            vec_idx_q <= vec_idx_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cin_q     <= cin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            ffi_q     <= ffi_d;
        end
    end

    assign a_o            = a_q;
    assign b_o            = b_q;
    assign cin_o          = cin_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;

endmodule
